display_scan: RTL

DISPLAY_SCAN -- requirements
Module: display_scan

---
 rtl/display_pkg.sv | 14 +
 rtl/scan_prescaler.sv | 33 +++
 rtl/display_scan.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/display_pkg.sv
// Shared constants and types for the multiplexed seven-segment scanner.
package display_pkg;

    localparam logic [3:0] BLANK_CODE = 4'hF;

    typedef logic [3:0] digit_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GUARD = 2'd1,
        SHOW  = 2'd2
    } scan_state_t;

endpackage

// File: rtl/scan_prescaler.sv
// Slot counter for the display scanner: counts 0..REFRESH_DIV-1 while the
// scan is active and flags the last cycle of each slot.
module scan_prescaler #(
    parameter int unsigned REFRESH_DIV = 50000,
    parameter int unsigned CW          = $clog2(REFRESH_DIV)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          active,
    input  logic          en,
    output logic [CW-1:0] cnt,
    output logic          tick
);

    localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);

    logic last;

    assign last = (cnt == CNT_MAX);
    assign tick = active && last;

    // Counter is held at zero whenever the scan is (or is about to be) idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (active && en) begin
            cnt <= last ? '0 : cnt + CW'(1);
        end else begin
            cnt <= '0;
        end
    end

endmodule

// File: rtl/display_scan.sv
// Multiplexed digit scanner with per-frame snapshot and anode guard time.
// Optional leading-zero blanking is enabled by defining LEADING_ZERO_BLANK_EN.
module display_scan
    import display_pkg::*;
#(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned REFRESH_DIV  = 50000,
    parameter int unsigned GUARD_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en_i,
    input  logic [4*NUM_DIGITS-1:0] value_i,
    input  logic [NUM_DIGITS-1:0]   dp_i,
    output logic [3:0]              data_o,
    output logic [NUM_DIGITS-1:0]   an_o,
    output logic                    dp_o,
    output logic                    frame_o
);

    localparam int unsigned     CW         = $clog2(REFRESH_DIV);
    localparam int unsigned     IW         = $clog2(NUM_DIGITS);
    localparam logic [IW-1:0]   IDX_MAX    = IW'(NUM_DIGITS - 1);
    localparam logic [CW-1:0]   GUARD_END  = CW'(GUARD_CYCLES - 1);
    localparam scan_state_t     SLOT_START = (GUARD_CYCLES == 0) ? SHOW : GUARD;

    scan_state_t             state;
    scan_state_t             state_next;
    logic [IW-1:0]           idx;
    logic [IW-1:0]           idx_next;
    logic [CW-1:0]           cnt;
    logic                    tick;
    logic                    capture;
    digit_t [NUM_DIGITS-1:0] snap;
    digit_t [NUM_DIGITS-1:0] snap_new;
    logic [NUM_DIGITS-1:0]   snap_dp;

    scan_prescaler #(
        .REFRESH_DIV(REFRESH_DIV),
        .CW         (CW)
    ) u_prescaler (
        .clk   (clk),
        .rst   (rst),
        .active(state != IDLE),
        .en    (en_i),
        .cnt   (cnt),
        .tick  (tick)
    );

    // Blanking is folded into the captured snapshot so display reads it directly.
    always_comb begin
`ifdef LEADING_ZERO_BLANK_EN
        logic seen;
        seen = 1'b0;
`endif
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            int unsigned j;
            j = NUM_DIGITS - 1 - i;
            snap_new[j] = value_i[4*j +: 4];
`ifdef LEADING_ZERO_BLANK_EN
            if (!seen && (j != 0) && (snap_new[j] == 4'h0)) begin
                snap_new[j] = BLANK_CODE;
            end
            if (value_i[4*j +: 4] != 4'h0) begin
                seen = 1'b1;
            end
`endif
        end
    end

    always_comb begin
        state_next = state;
        idx_next   = idx;
        capture    = 1'b0;
        unique case (state)
            IDLE: begin
                idx_next = '0;
                if (en_i) begin
                    state_next = SLOT_START;
                    capture    = 1'b1;
                end
            end
            GUARD, SHOW: begin
                if (!en_i) begin
                    state_next = IDLE;
                    idx_next   = '0;
                end else if (tick) begin
                    state_next = SLOT_START;
                    if (idx == IDX_MAX) begin
                        idx_next = '0;
                        capture  = 1'b1;
                    end else begin
                        idx_next = idx + IW'(1);
                    end
                end else if ((state == GUARD) && (cnt == GUARD_END)) begin
                    state_next = SHOW;
                end
            end
            default: begin
                state_next = IDLE;
                idx_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            idx     <= '0;
            snap    <= {NUM_DIGITS{BLANK_CODE}};
            snap_dp <= '0;
            frame_o <= 1'b0;
        end else begin
            state   <= state_next;
            idx     <= idx_next;
            frame_o <= capture;
            if (capture) begin
                snap    <= snap_new;
                snap_dp <= dp_i;
            end
        end
    end

    always_comb begin
        an_o   = '1;
        dp_o   = 1'b1;
        data_o = BLANK_CODE;
        case (state)
            GUARD: begin
                data_o = snap[idx];
            end
            SHOW: begin
                an_o[idx] = 1'b0;
                data_o    = snap[idx];
                dp_o      = ~snap_dp[idx];
            end
            default: ;
        endcase
    end

endmodule
